tcdm_lic_xbar: RTL and testbench

- Full NumIn×NumOut logarithmic crossbar for TCDM-style banked memory.
- Each master gets a bank address decoder and a response mux.
- Each slave port gets a round-robin arbitration tree.
- Sits between cluster cores/DMA (masters) and SRAM banks (slaves); single-cycle grant path, fixed-latency response return.

---
 rtl/tcdm_lic_xbar_pkg.sv | 15 +
 rtl/tcdm_lic_xbar_rr_arb_tree.sv | 86 ++++++++
 rtl/tcdm_lic_xbar.sv | 112 +++++++++++
 tb/tb_tcdm_lic_xbar.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_lic_xbar_pkg.sv
// Shared elaboration helpers for the TCDM logarithmic crossbar.
// Latency: n/a (constant functions only).
// Backpressure: n/a.
package tcdm_lic_xbar_pkg;

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcdm_lic_xbar_rr_arb_tree.sv
// Binary round-robin arbitration tree with payload mux, one per bank.
// Latency: combinational request/grant/data path; priority counter updates on handshake.
// Backpressure: gnt_i=0 blocks every grant; the selected payload is still presented.
module rr_arb_tree
    import tcdm_lic_xbar_pkg::*;
#(
    parameter int unsigned NumIn     = 4,
    parameter int unsigned DataWidth = 32,
    parameter bit          ExtPrio   = 1'b1,
    localparam int unsigned IdxW     = idx_width(NumIn)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic [IdxW-1:0]                     rr_i,
    input  logic [NumIn-1:0]                    req_i,
    output logic [NumIn-1:0]                    gnt_o,
    input  logic [NumIn-1:0][DataWidth-1:0]     data_i,
    input  logic                                gnt_i,
    output logic                                req_o,
    output logic [DataWidth-1:0]                data_o,
    output logic [IdxW-1:0]                     idx_o
);

    if (NumIn == 1) begin : gen_bypass
        assign req_o  = req_i[0];
        assign gnt_o  = gnt_i;
        assign data_o = data_i[0];
        assign idx_o  = '0;
    end else begin : gen_tree
        localparam int unsigned NumLvl   = $clog2(NumIn);
        localparam int unsigned NumNodes = 2 * NumIn - 1;

        logic [IdxW-1:0]                    prio, rr_d, rr_q;
        logic [NumNodes-1:0]                node_req, node_gnt;
        logic [NumNodes-1:0][IdxW-1:0]      node_idx;
        logic [NumNodes-1:0][DataWidth-1:0] node_dat;
        logic [NumIn-2:0]                   node_sel;

        assign prio = ExtPrio ? rr_i : rr_q;

        // Heap layout: node 0 is the root, leaves occupy NumIn-1 .. 2*NumIn-2.
        for (genvar j = 0; j < NumIn; j++) begin : gen_leaf
            assign node_req[NumIn-1+j] = req_i[j];
            assign node_idx[NumIn-1+j] = IdxW'(j);
            assign node_dat[NumIn-1+j] = data_i[j];
            assign gnt_o[j]            = node_gnt[NumIn-1+j] & req_i[j];
        end

        for (genvar d = 0; d < NumLvl; d++) begin : gen_lvl
            for (genvar i = 0; i < (2 ** d); i++) begin : gen_node
                localparam int unsigned N   = (2 ** d) - 1 + i;
                localparam int unsigned Lvl = NumLvl - 1 - d;
                assign node_sel[N]     = ~node_req[2*N+1] | (node_req[2*N+2] & prio[Lvl]);
                assign node_req[N]     = node_req[2*N+1] | node_req[2*N+2];
                assign node_idx[N]     = node_sel[N] ? node_idx[2*N+2] : node_idx[2*N+1];
                assign node_dat[N]     = node_sel[N] ? node_dat[2*N+2] : node_dat[2*N+1];
                assign node_gnt[2*N+1] = node_gnt[N] & ~node_sel[N];
                assign node_gnt[2*N+2] = node_gnt[N] &  node_sel[N];
            end
        end

        assign node_gnt[0] = gnt_i;
        assign req_o       = node_req[0];
        assign data_o      = node_dat[0];
        assign idx_o       = node_idx[0];

        always_comb begin
            rr_d = rr_q;
            if (flush_i) begin
                rr_d = '0;
            end else if (req_o && gnt_i) begin
                rr_d = rr_q + IdxW'(1);
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                rr_q <= '0;
            end else begin
                rr_q <= rr_d;
            end
        end
    end

endmodule

// File: rtl/tcdm_lic_xbar.sv
// NumIn x NumOut logarithmic crossbar between cluster masters and TCDM banks.
// Latency: grant is combinational; response returns exactly RespLat cycles after handshake.
// Backpressure: losing or stalled masters see gnt_o=0 and must hold their request.
module tcdm_lic_xbar
    import tcdm_lic_xbar_pkg::*;
#(
    parameter int unsigned NumIn         = 4,
    parameter int unsigned NumOut        = 4,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32,
    parameter int unsigned RespLat       = 1,
    parameter bit          WriteRespOn   = 1'b1,
    parameter bit          BroadCastOn   = 1'b0,
    parameter bit          ExtPrio       = 1'b1,
    localparam int unsigned AddW         = idx_width(NumOut),
    localparam int unsigned InIdxW       = idx_width(NumIn)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NumIn-1:0]                        req_i,
    input  logic [NumIn-1:0][AddW-1:0]              add_i,
    input  logic [NumIn-1:0]                        wen_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]      wdata_i,
    output logic [NumIn-1:0]                        gnt_o,
    output logic [NumIn-1:0]                        vld_o,
    output logic [NumIn-1:0][RespDataWidth-1:0]     rdata_o,
    input  logic [NumOut-1:0][InIdxW-1:0]           rr_i,
    input  logic [NumOut-1:0]                       gnt_i,
    output logic [NumOut-1:0]                       req_o,
    output logic [NumOut-1:0][ReqDataWidth-1:0]     wdata_o,
    input  logic [NumOut-1:0][RespDataWidth-1:0]    rdata_i
);

    if (!is_pow2(NumIn) || !is_pow2(NumOut) || (NumOut < 2) || (RespLat < 1)) begin : gen_param_err
        $error("tcdm_lic_xbar: NumIn and NumOut must be powers of two (NumOut >= 2), RespLat >= 1");
    end

    logic [NumOut-1:0][NumIn-1:0]  sl_req, sl_gnt;
    logic [NumOut-1:0][InIdxW-1:0] sl_idx;
    logic [NumIn-1:0]              push_vld;

    for (genvar k = 0; k < NumOut; k++) begin : gen_slave
        for (genvar j = 0; j < NumIn; j++) begin : gen_dec
            assign sl_req[k][j] = req_i[j] & (BroadCastOn | (add_i[j] == AddW'(k)));
        end

        rr_arb_tree #(
            .NumIn     (NumIn),
            .DataWidth (ReqDataWidth),
            .ExtPrio   (ExtPrio)
        ) i_arb (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (1'b0),
            .rr_i    (rr_i[k]),
            .req_i   (sl_req[k]),
            .gnt_o   (sl_gnt[k]),
            .data_i  (wdata_i),
            .gnt_i   (gnt_i[k]),
            .req_o   (req_o[k]),
            .data_o  (wdata_o[k]),
            .idx_o   (sl_idx[k])
        );

        // A granted bank hands its grant to exactly the master the tree selected.
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            (req_o[k] && gnt_i[k]) |-> (sl_gnt[k] == (NumIn'(1) << sl_idx[k])));
    end

    for (genvar j = 0; j < NumIn; j++) begin : gen_master
        logic [RespLat-1:0]           vld_d, vld_q;
        logic [RespLat-1:0][AddW-1:0] idx_d, idx_q;

        if (BroadCastOn) begin : gen_bc_gnt
            logic [NumOut-1:0] col_gnt;
            for (genvar k = 0; k < NumOut; k++) begin : gen_col
                assign col_gnt[k] = sl_gnt[k][j];
            end
            assign gnt_o[j] = &col_gnt;
        end else begin : gen_uc_gnt
            assign gnt_o[j] = sl_gnt[add_i[j]][j];
        end

        assign push_vld[j] = req_i[j] & gnt_o[j] & (~wen_i[j] | WriteRespOn);

        always_comb begin
            vld_d    = vld_q;
            idx_d    = idx_q;
            vld_d[0] = push_vld[j];
            idx_d[0] = add_i[j];
            for (int s = 1; s < RespLat; s++) begin
                vld_d[s] = vld_q[s-1];
                idx_d[s] = idx_q[s-1];
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                vld_q <= '0;
                idx_q <= '0;
            end else begin
                vld_q <= vld_d;
                idx_q <= idx_d;
            end
        end

        // Data mux follows the tail bank index whether or not the tail is valid.
        assign vld_o[j]   = vld_q[RespLat-1];
        assign rdata_o[j] = rdata_i[idx_q[RespLat-1]];
    end

endmodule

// File: tb/tb_tcdm_lic_xbar.sv
// Bench for tcdm_lic_xbar: three configurations driven from shared inputs and
// checked against a bank-level behavioural model of arbitration and response timing.
module tb_tcdm_lic_xbar;

    localparam int LAT [3] = '{1, 2, 1};
    localparam int WR  [3] = '{1, 0, 1};
    localparam int EP  [3] = '{1, 0, 1};
    localparam int BC  [3] = '{0, 0, 1};

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req, wen, gnt_in;
    logic [3:0][1:0]  add, rr_in;
    logic [3:0][31:0] wdata, rdata_in;

    logic [3:0]       gnt_x [3];
    logic [3:0]       vld_x [3];
    logic [3:0]       req_x [3];
    logic [3:0][31:0] rdo_x [3];
    logic [3:0][31:0] wdo_x [3];

    bit               mv  [3][2][4];
    logic [1:0]       mb  [3][2][4];
    int               rrm [3][4];
    logic [3:0]       e_gnt [3];
    logic [3:0]       e_req [3];
    logic [3:0]       e_vld [3];
    logic [3:0][31:0] e_wdo [3];
    logic [3:0][31:0] e_rdo [3];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    tcdm_lic_xbar u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
        .gnt_o(gnt_x[0]), .vld_o(vld_x[0]), .rdata_o(rdo_x[0]), .rr_i(rr_in), .gnt_i(gnt_in),
        .req_o(req_x[0]), .wdata_o(wdo_x[0]), .rdata_i(rdata_in)
    );

    tcdm_lic_xbar #(.RespLat(2), .WriteRespOn(1'b0), .ExtPrio(1'b0)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
        .gnt_o(gnt_x[1]), .vld_o(vld_x[1]), .rdata_o(rdo_x[1]), .rr_i(rr_in), .gnt_i(gnt_in),
        .req_o(req_x[1]), .wdata_o(wdo_x[1]), .rdata_i(rdata_in)
    );

    tcdm_lic_xbar #(.BroadCastOn(1'b1)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
        .gnt_o(gnt_x[2]), .vld_o(vld_x[2]), .rdata_o(rdo_x[2]), .rr_i(rr_in), .gnt_i(gnt_in),
        .req_o(req_x[2]), .wdata_o(wdo_x[2]), .rdata_i(rdata_in)
    );

    // Winner among requesters: walk halves from the widest split down, taking the
    // upper half when the lower is idle or both are busy and the priority bit is set.
    function automatic int pick(input logic [3:0] r, input int p);
        int base = 0;
        int span = 4;
        for (int b = 1; b >= 0; b--) begin
            int half;
            bit lo, up;
            half = span / 2;
            lo = 1'b0;
            up = 1'b0;
            for (int i = 0; i < half; i++) begin
                lo = lo | r[base+i];
                up = up | r[base+half+i];
            end
            if (!lo || (up && p[b])) base = base + half;
            span = half;
        end
        return base;
    endfunction

    task automatic model_eval();
        for (int d = 0; d < 3; d++) begin
            logic [3:0] gk [4];
            for (int k = 0; k < 4; k++) begin
                logic [3:0] rk;
                int p, w;
                p = (EP[d] != 0) ? int'(rr_in[k]) : rrm[d][k];
                for (int j = 0; j < 4; j++) rk[j] = req[j] && ((BC[d] != 0) || (int'(add[j]) == k));
                w = pick(rk, p);
                e_req[d][k] = |rk;
                e_wdo[d][k] = wdata[w];
                for (int j = 0; j < 4; j++) gk[k][j] = gnt_in[k] && rk[j] && (j == w);
            end
            for (int j = 0; j < 4; j++) begin
                if (BC[d] != 0) e_gnt[d][j] = gk[0][j] & gk[1][j] & gk[2][j] & gk[3][j];
                else            e_gnt[d][j] = gk[add[j]][j];
                e_vld[d][j] = mv[d][LAT[d]-1][j];
                e_rdo[d][j] = rdata_in[mb[d][LAT[d]-1][j]];
            end
        end
    endtask

    task automatic model_update();
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                for (int s = 0; s < 2; s++)
                    for (int j = 0; j < 4; j++) begin
                        mv[d][s][j] = 1'b0;
                        mb[d][s][j] = 2'd0;
                    end
                for (int k = 0; k < 4; k++) rrm[d][k] = 0;
            end else begin
                for (int s = LAT[d] - 1; s >= 1; s--)
                    for (int j = 0; j < 4; j++) begin
                        mv[d][s][j] = mv[d][s-1][j];
                        mb[d][s][j] = mb[d][s-1][j];
                    end
                for (int j = 0; j < 4; j++) begin
                    mv[d][0][j] = req[j] && e_gnt[d][j] && (!wen[j] || (WR[d] != 0));
                    mb[d][0][j] = add[j];
                end
                for (int k = 0; k < 4; k++)
                    if (e_req[d][k] && gnt_in[k]) rrm[d][k] = (rrm[d][k] + 1) % 4;
            end
        end
    endtask

    task automatic tick();
        model_eval();
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; wen = '0; gnt_in = 4'hF; rr_in = '0;
        for (int k = 0; k < 4; k++) rdata_in[k] = $urandom;
        tick();
        tick();
        #1;
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (vld_x[d] !== 4'h0) $display("FAIL reset_vld dut%0d: got %h want 0", d, vld_x[d]);
            else n_pass++;
            n_chk++;
            if (req_x[d] !== 4'h0) $display("FAIL reset_req dut%0d: got %h want 0", d, req_x[d]);
            else n_pass++;
            n_chk++;
            if (gnt_x[d] !== 4'h0) $display("FAIL reset_gnt dut%0d: got %h want 0", d, gnt_x[d]);
            else n_pass++;
            for (int j = 0; j < 4; j++) begin
                n_chk++;
                if (rdo_x[d][j] !== rdata_in[0])
                    $display("FAIL reset_rdata dut%0d m%0d: got %h want %h", d, j, rdo_x[d][j], rdata_in[0]);
                else n_pass++;
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        req = '0;
        for (int c = 0; c < 5; c++) begin
            gnt_in = 4'($urandom);
            rr_in  = 8'($urandom);
            for (int k = 0; k < 4; k++) rdata_in[k] = $urandom;
            #1;
            for (int d = 0; d < 3; d++) begin
                n_chk++;
                if ({req_x[d], gnt_x[d], vld_x[d]} !== 12'h0)
                    $display("FAIL idle dut%0d c%0d: req/gnt/vld %h/%h/%h want 0", d, c, req_x[d], gnt_x[d], vld_x[d]);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_disjoint();
        do_reset();
        req = 4'hF; wen = '0; gnt_in = 4'hF; rr_in = '0;
        for (int j = 0; j < 4; j++) begin
            add[j]      = 2'(3 - j);
            wdata[j]    = $urandom;
            rdata_in[j] = 32'hA0 + 32'(j);
        end
        #1;
        n_chk++;
        if (gnt_x[0] !== 4'hF) $display("FAIL disjoint_gnt dut0: got %h want f", gnt_x[0]); else n_pass++;
        n_chk++;
        if (gnt_x[1] !== 4'hF) $display("FAIL disjoint_gnt dut1: got %h want f", gnt_x[1]); else n_pass++;
        n_chk++;
        if (gnt_x[2] !== 4'h1) $display("FAIL broadcast_gnt dut2: got %h want 1", gnt_x[2]); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (wdo_x[0][k] !== wdata[3-k])
                $display("FAIL disjoint_wdata bank%0d: got %h want %h", k, wdo_x[0][k], wdata[3-k]);
            else n_pass++;
        end
        tick();
        req = '0;
        #1;
        n_chk++;
        if (vld_x[0] !== 4'hF) $display("FAIL disjoint_vld dut0: got %h want f", vld_x[0]); else n_pass++;
        n_chk++;
        if (vld_x[1] !== 4'h0) $display("FAIL disjoint_vld_early dut1: got %h want 0", vld_x[1]); else n_pass++;
        n_chk++;
        if (vld_x[2] !== 4'h1) $display("FAIL broadcast_vld dut2: got %h want 1", vld_x[2]); else n_pass++;
        for (int j = 0; j < 4; j++) begin
            n_chk++;
            if (rdo_x[0][j] !== 32'hA0 + 32'(3 - j))
                $display("FAIL disjoint_rdata dut0 m%0d: got %h want %h", j, rdo_x[0][j], 32'hA0 + 32'(3 - j));
            else n_pass++;
        end
        tick();
        #1;
        n_chk++;
        if (vld_x[1] !== 4'hF) $display("FAIL disjoint_vld dut1: got %h want f", vld_x[1]); else n_pass++;
        n_chk++;
        if (vld_x[0] !== 4'h0) $display("FAIL disjoint_vld_drop dut0: got %h want 0", vld_x[0]); else n_pass++;
        for (int j = 0; j < 4; j++) begin
            n_chk++;
            if (rdo_x[1][j] !== 32'hA0 + 32'(3 - j))
                $display("FAIL disjoint_rdata dut1 m%0d: got %h want %h", j, rdo_x[1][j], 32'hA0 + 32'(3 - j));
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_conflict();
        do_reset();
        req = 4'b1001; wen = '0; gnt_in = 4'hF; rr_in = '0;
        add[0] = 2'd2; add[3] = 2'd2; add[1] = 2'd0; add[2] = 2'd1;
        for (int j = 0; j < 4; j++) wdata[j] = $urandom;
        #1;
        n_chk++;
        if (gnt_x[0] !== 4'b0001) $display("FAIL conflict_rr0_gnt: got %b want 0001", gnt_x[0]); else n_pass++;
        n_chk++;
        if (wdo_x[0][2] !== wdata[0]) $display("FAIL conflict_rr0_wdata: got %h want %h", wdo_x[0][2], wdata[0]); else n_pass++;
        n_chk++;
        if (req_x[0] !== 4'b0100) $display("FAIL conflict_req: got %b want 0100", req_x[0]); else n_pass++;
        tick();
        rr_in[2] = 2'd3;
        #1;
        n_chk++;
        if (gnt_x[0] !== 4'b1000) $display("FAIL conflict_rr3_gnt: got %b want 1000", gnt_x[0]); else n_pass++;
        n_chk++;
        if (wdo_x[0][2] !== wdata[3]) $display("FAIL conflict_rr3_wdata: got %h want %h", wdo_x[0][2], wdata[3]); else n_pass++;
        tick();
        gnt_in[2] = 1'b0;
        #1;
        n_chk++;
        if (gnt_x[0] !== 4'b0000) $display("FAIL conflict_stall_gnt: got %b want 0000", gnt_x[0]); else n_pass++;
        n_chk++;
        if (wdo_x[0][2] !== wdata[3]) $display("FAIL conflict_stall_wdata: got %h want %h", wdo_x[0][2], wdata[3]); else n_pass++;
        tick();
    endtask

    task automatic test_internal_rr();
        do_reset();
        req = 4'hF; wen = '0; gnt_in = 4'hF;
        for (int j = 0; j < 4; j++) add[j] = 2'd1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_chk++;
            if (gnt_x[1] !== (4'b0001 << c))
                $display("FAIL internal_rr c%0d: got %b want %b", c, gnt_x[1], 4'b0001 << c);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_store();
        do_reset();
        req = 4'b0001; wen = 4'b0001; gnt_in = 4'hF; add[0] = 2'd0;
        #1;
        n_chk++;
        if (gnt_x[0][0] !== 1'b1) $display("FAIL store_gnt dut0: got %b want 1", gnt_x[0][0]); else n_pass++;
        n_chk++;
        if (gnt_x[1][0] !== 1'b1) $display("FAIL store_gnt dut1: got %b want 1", gnt_x[1][0]); else n_pass++;
        tick();
        req = '0; wen = '0;
        #1;
        n_chk++;
        if (vld_x[0] !== 4'b0001) $display("FAIL store_vld dut0: got %b want 0001", vld_x[0]); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            if (c != 0) #1;
            n_chk++;
            if (vld_x[1] !== 4'b0000) $display("FAIL store_novld dut1 c%0d: got %b want 0000", c, vld_x[1]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 4'b0100; wen = '0; add[2] = 2'd3; gnt_in = 4'b0111;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_chk++;
            if ({req_x[1][3], gnt_x[1], vld_x[1]} !== 9'b1_0000_0000)
                $display("FAIL bp_stall c%0d: req3/gnt/vld %b/%b/%b want 1/0000/0000", c, req_x[1][3], gnt_x[1], vld_x[1]);
            else n_pass++;
            tick();
        end
        gnt_in = 4'hF;
        #1;
        n_chk++;
        if (gnt_x[1] !== 4'b0100) $display("FAIL bp_release_gnt: got %b want 0100", gnt_x[1]); else n_pass++;
        tick();
        req = '0;
        #1;
        n_chk++;
        if (vld_x[1] !== 4'b0000) $display("FAIL bp_lat1_vld: got %b want 0000", vld_x[1]); else n_pass++;
        tick();
        #1;
        n_chk++;
        if (vld_x[1] !== 4'b0100) $display("FAIL bp_lat2_vld: got %b want 0100", vld_x[1]); else n_pass++;
        tick();
        #1;
        n_chk++;
        if (vld_x[1] !== 4'b0000) $display("FAIL bp_lat3_vld: got %b want 0000", vld_x[1]); else n_pass++;
        tick();
        req = 4'b0100;
        tick();
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (gnt_x[1] !== 4'b0100) $display("FAIL bp_gnt_in_reset: got %b want 0100", gnt_x[1]); else n_pass++;
        tick();
        rst_n = 1'b1; req = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_chk++;
            if (vld_x[1] !== 4'b0000) $display("FAIL bp_reset_drop c%0d: got %b want 0000", c, vld_x[1]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n  = ($urandom_range(19) != 0);
            req    = 4'($urandom);
            wen    = 4'($urandom);
            add    = 8'($urandom);
            rr_in  = 8'($urandom);
            gnt_in = 4'($urandom);
            for (int j = 0; j < 4; j++) begin
                wdata[j]    = $urandom;
                rdata_in[j] = $urandom;
            end
            #1;
            model_eval();
            for (int d = 0; d < 3; d++) begin
                n_chk++;
                if (gnt_x[d] !== e_gnt[d]) $display("FAIL rand_gnt dut%0d c%0d: got %b want %b", d, c, gnt_x[d], e_gnt[d]);
                else n_pass++;
                n_chk++;
                if (req_x[d] !== e_req[d]) $display("FAIL rand_req dut%0d c%0d: got %b want %b", d, c, req_x[d], e_req[d]);
                else n_pass++;
                n_chk++;
                if (vld_x[d] !== e_vld[d]) $display("FAIL rand_vld dut%0d c%0d: got %b want %b", d, c, vld_x[d], e_vld[d]);
                else n_pass++;
                for (int k = 0; k < 4; k++) begin
                    n_chk++;
                    if (wdo_x[d][k] !== e_wdo[d][k])
                        $display("FAIL rand_wdata dut%0d c%0d b%0d: got %h want %h", d, c, k, wdo_x[d][k], e_wdo[d][k]);
                    else n_pass++;
                    n_chk++;
                    if (rdo_x[d][k] !== e_rdo[d][k])
                        $display("FAIL rand_rdata dut%0d c%0d m%0d: got %h want %h", d, c, k, rdo_x[d][k], e_rdo[d][k]);
                    else n_pass++;
                end
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; wen = '0; add = '0; rr_in = '0;
        gnt_in = '0; wdata = '0; rdata_in = '0;
        test_reset();
        test_idle();
        test_disjoint();
        test_conflict();
        test_internal_rr();
        test_store();
        test_backpressure();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
